// File: rtl/sig_gen_if.sv
// Bus bundle for sig_gen: configuration handshake, run control and waveform/status outputs.
interface sig_gen_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic [WIDTH-1:0] burst;
    logic             start;
    logic             stop;
    logic             sig;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] edge_count;

    modport master (
        output cfg_valid, period, high_time, burst, start, stop,
        input  cfg_ready, sig, busy, done, edge_count
    );

    modport slave (
        input  cfg_valid, period, high_time, burst, start, stop,
        output cfg_ready, sig, busy, done, edge_count
    );
endinterface

// File: rtl/sig_gen.sv
// Programmable pulse-train generator (continuous or burst) driving the test stimulus sig.
// Optional macro SIG_GEN_EDGE_COUNT_EN enables edge_count and burst termination.
module sig_gen #(
    parameter int unsigned WIDTH = 16
) (
    input logic    clk,
    input logic    rst,
    sig_gen_if.slave bus
);
`ifdef SIG_GEN_EDGE_COUNT_EN
    localparam bit EdgeCountEn = 1'b1;
`else
    localparam bit EdgeCountEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] bst_q, bst_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;

    logic [WIDTH-1:0] per_new, hi_new;
    logic             cfg_fire, high_end, low_end, burst_hit;

    // Period is at least 2 so that both phases last at least one cycle.
    always_comb begin
        per_new = (bus.period < WIDTH'(2)) ? WIDTH'(2) : bus.period;
        hi_new  = bus.high_time;
        if (hi_new == '0) begin
            hi_new = WIDTH'(1);
        end else if (hi_new >= per_new) begin
            hi_new = per_new - WIDTH'(1);
        end
    end

    always_comb begin
        cfg_fire  = bus.cfg_valid && (state_q == ST_IDLE);
        high_end  = (phase_q == hi_q - WIDTH'(1));
        low_end   = (phase_q == per_q - hi_q - WIDTH'(1));
        burst_hit = (bst_q != '0) && (cnt_q == bst_q);
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        bst_d   = bst_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        done_d  = 1'b0;
        pend_d  = pend_q;

        if (cfg_fire) begin
            per_d = per_new;
            hi_d  = hi_new;
            bst_d = EdgeCountEn ? bus.burst : '0;
        end

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                sig_d  = 1'b0;
                if (bus.start) begin
                    state_d = ST_HIGH;
                    phase_d = '0;
                    sig_d   = 1'b1;
                    cnt_d   = WIDTH'(1);
                end
            end
            ST_HIGH: begin
                if (bus.stop) begin
                    pend_d = 1'b1;
                end
                if (high_end) begin
                    state_d = ST_LOW;
                    phase_d = '0;
                    sig_d   = 1'b0;
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                end
            end
            ST_LOW: begin
                if (low_end) begin
                    if (pend_q || burst_hit) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_HIGH;
                        phase_d = '0;
                        sig_d   = 1'b1;
                        // A stop landing on the period boundary belongs to the new period.
                        pend_d  = bus.stop;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                    if (bus.stop) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = 1'b0;
            end
        endcase

        if (!EdgeCountEn) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            per_q   <= WIDTH'(2);
            hi_q    <= WIDTH'(1);
            bst_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            bst_q   <= bst_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.cfg_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.sig        = sig_q;
    assign bus.done       = done_q;
    assign bus.edge_count = cnt_q;
endmodule

// File: tb/tb_sig_gen.sv
// Directed bench for sig_gen: waveform shape, clamping, stop/burst termination, config gating, reset.
module tb_sig_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    sig_gen_if #(.WIDTH(16)) bus();

    sig_gen #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (k=%0d): got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int p);
`ifdef SIG_GEN_EDGE_COUNT_EN
        return ((k - 1) / p) + 1;
`else
        return 0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int p, input int h);
        tick;
        k++;
        check("sig",   bus.sig, (((k - 1) % p) < h) ? 1 : 0);
        check("busy",  bus.busy, 1);
        check("rdy",   bus.cfg_ready, 0);
        check("done",  bus.done, 0);
        check("ecnt",  bus.edge_count, exp_cnt(p));
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_sig"},  bus.sig, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_rdy"},  bus.cfg_ready, 1);
        check({tag, "_done"}, bus.done, 0);
    endtask

    task automatic set_cfg(input int p, input int h, input int b);
        bus.cfg_valid = 1'b1;
        bus.period    = 16'(p);
        bus.high_time = 16'(h);
        bus.burst     = 16'(b);
    endtask

    task automatic start_run(input int p, input int h);
        bus.start = 1'b1;
        k = 0;
        step(p, h);
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic end_run(input int p, input int h);
        int target;
        bus.stop = 1'b1;
        step(p, h);
        bus.stop = 1'b0;
        target = ((k - 1) / p) * p + p + 1;
        while (k < target - 1) step(p, h);
        tick;
        k++;
        check("end_done", bus.done, 1);
        check("end_busy", bus.busy, 0);
        check("end_sig",  bus.sig, 0);
        check("end_rdy",  bus.cfg_ready, 1);
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.period    = '0;
        bus.high_time = '0;
        bus.burst     = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        rst           = 1'b1;
        tick;
        tick;
        idle_check("rst");
        check("rst_ecnt", bus.edge_count, 0);
        rst = 1'b0;
        tick;
        idle_check("rst_rel");

        // Period 10, high 3, burst 4
        set_cfg(10, 3, 4);
        start_run(10, 3);
`ifdef SIG_GEN_EDGE_COUNT_EN
        repeat (39) step(10, 3);
        tick;
        k++;
        check("burst_done", bus.done, 1);
        check("burst_busy", bus.busy, 0);
        check("burst_sig",  bus.sig, 0);
        check("burst_ecnt", bus.edge_count, 4);
        check("burst_rdy",  bus.cfg_ready, 1);
`else
        repeat (44) step(10, 3);
        end_run(10, 3);
`endif
        repeat (3) begin
            tick;
            idle_check("a_after");
        end

        // Stop in IDLE ignored; start+stop together takes start; period 1/high 0 clamps to 2/1
        bus.stop = 1'b1;
        tick;
        idle_check("b_stop_idle");
        set_cfg(1, 0, 0);
        start_run(2, 1);
        repeat (8) step(2, 1);
        end_run(2, 1);

        // Period 5, high 9 clamps to 4; start while busy ignored
        set_cfg(5, 9, 0);
        start_run(5, 4);
        repeat (5) step(5, 4);
        bus.start = 1'b1;
        step(5, 4);
        bus.start = 1'b0;
        repeat (6) step(5, 4);
        end_run(5, 4);
        tick;
        idle_check("c_after");

        // Config offered while busy is refused; taken with start at the done cycle
        set_cfg(6, 2, 0);
        start_run(6, 2);
        repeat (3) step(6, 2);
        set_cfg(20, 5, 0);
        repeat (8) step(6, 2);
        end_run(6, 2);
        start_run(20, 5);
        repeat (24) step(20, 5);
        end_run(20, 5);
        tick;
        idle_check("d_after");

        // Reset two cycles into HIGH: immediate idle, no done, stored config back to 2/1
        set_cfg(10, 6, 0);
        start_run(10, 6);
        step(10, 6);
        rst = 1'b1;
        tick;
        idle_check("e_rst");
        check("e_rst_ecnt", bus.edge_count, 0);
        rst = 1'b0;
        tick;
        idle_check("e_rel");
        check("e_rel_ecnt", bus.edge_count, 0);
        start_run(2, 1);
        repeat (4) step(2, 1);
        end_run(2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
